dispatch_queue_unit: RTL

// Parametrised dispatch stage: classifies each decoded instruction, builds its operand entry
//  and enqueues it into one of four per-unit FIFOs: 0=INT, 1=MULT, 2=DIV, 3=LD_ST.

---
 rtl/dispatch_queue_unit.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_queue_unit.sv
// Dispatch stage: sorts decoded instructions into INT/MULT/DIV/LD_ST FIFOs, wakes pending
// operands from the CDB while queued, and stalls dispatch behind an unresolved branch.
module dispatch_queue_unit #(
   parameter  int XLEN  = 32,
   parameter  int TAG_W = 6,
   parameter  int DEPTH = 4,
   localparam int PW    = 2*XLEN + 3*TAG_W + 20,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [6:0]         opcode,
   input  logic [2:0]         func3,
   input  logic [6:0]         func7,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic [XLEN-1:0]    rs1_data,
   input  logic [XLEN-1:0]    rs2_data,
   input  logic [TAG_W:0]     rs1_tag,
   input  logic [TAG_W:0]     rs2_tag,
   input  logic [TAG_W-1:0]   rd_tag,
   input  logic [XLEN-1:0]    immediate,
   input  logic               cdb_valid,
   input  logic [TAG_W-1:0]   cdb_tag,
   input  logic [XLEN-1:0]    cdb_data,
   input  logic               br_resolve,
   input  logic               flush,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*PW-1:0]    out_data,
   output logic [4*CNT_W-1:0] out_count,
   output logic               illegal
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] CH_INT  = 2'd0;
   localparam logic [1:0] CH_MULT = 2'd1;
   localparam logic [1:0] CH_DIV  = 2'd2;
   localparam logic [1:0] CH_LDST = 2'd3;

   typedef enum logic {ST_RUN = 1'b0, ST_BR_HOLD = 1'b1} state_e;

   typedef struct packed {
      logic [TAG_W-1:0] rd_tag;
      logic [XLEN-1:0]  rs2_data;
      logic [TAG_W-1:0] rs2_tag;
      logic             rs2_valid;
      logic [XLEN-1:0]  rs1_data;
      logic [TAG_W-1:0] rs1_tag;
      logic             rs1_valid;
      logic             st;
      logic [6:0]       func7;
      logic [2:0]       func3;
      logic [6:0]       opcode;
   } entry_t;

   // A pending operand whose tag is on the CDB takes the broadcast value.
   function automatic entry_t snoop(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
      entry_t r;
      r = e;
      if (v && !e.rs1_valid && (e.rs1_tag == t)) begin
         r.rs1_valid = 1'b1;
         r.rs1_data  = d;
      end
      if (v && !e.rs2_valid && (e.rs2_tag == t)) begin
         r.rs2_valid = 1'b1;
         r.rs2_data  = d;
      end
      return r;
   endfunction

   state_e           state_q;
   logic             illegal_q;
   entry_t           mem_q  [4][DEPTH];
   entry_t           mem_d  [4][DEPTH];
   logic [PTR_W-1:0] head_q [4];
   logic [PTR_W-1:0] head_d [4];
   logic [PTR_W-1:0] tail_q [4];
   logic [PTR_W-1:0] tail_d [4];
   logic [CNT_W-1:0] cnt_q  [4];
   logic [CNT_W-1:0] cnt_d  [4];

   logic [1:0] chan_s;
   logic       known_s;
   logic       st_s;
   logic       br_s;
   logic       imm_s;
   logic       ld_s;
   logic       full_s;
   logic       enq_s;
   logic [3:0] deq_s;
   logic [3:0] enq_ch_s;
   entry_t     raw_s;
   entry_t     new_s;

   // Decode the opcode into a target channel and operand-shaping flags.
   always_comb begin
      chan_s  = CH_INT;
      known_s = 1'b1;
      st_s    = 1'b0;
      br_s    = 1'b0;
      imm_s   = 1'b0;
      ld_s    = 1'b0;
      case (opcode)
         OP_R: begin
            if (func7 == 7'd1 && func3 == 3'd0) begin
               chan_s = CH_MULT;
            end else if (func7 == 7'd1 && func3 == 3'd4) begin
               chan_s = CH_DIV;
            end else begin
               chan_s = CH_INT;
            end
         end
         OP_IMM, OP_LUI:             imm_s = 1'b1;
         OP_AUIPC:                   chan_s = CH_INT;
         OP_LOAD: begin
            chan_s = CH_LDST;
            ld_s   = 1'b1;
         end
         OP_STORE: begin
            chan_s = CH_LDST;
            st_s   = 1'b1;
         end
         OP_BRANCH, OP_JAL, OP_JALR: br_s = 1'b1;
         default:                    known_s = 1'b0;
      endcase
   end

   // Assemble the incoming entry; OP-IMM/LUI carry the immediate in the rs2 slot.
   always_comb begin
      raw_s           = '0;
      raw_s.opcode    = opcode;
      raw_s.func3     = func3;
      raw_s.func7     = func7;
      raw_s.st        = st_s;
      raw_s.rs1_valid = (rs1 == 5'd0) || !rs1_tag[TAG_W];
      raw_s.rs1_tag   = rs1_tag[TAG_W-1:0];
      raw_s.rs1_data  = rs1_data;
      raw_s.rs2_valid = imm_s || ld_s || (rs2 == 5'd0) || !rs2_tag[TAG_W];
      raw_s.rs2_tag   = rs2_tag[TAG_W-1:0];
      raw_s.rs2_data  = imm_s ? immediate : rs2_data;
      raw_s.rd_tag    = rd_tag;
   end

   assign new_s    = snoop(raw_s, cdb_valid, cdb_tag, cdb_data);
   assign full_s   = (cnt_q[chan_s] == CNT_W'(DEPTH));
   assign in_ready = !flush && (state_q == ST_RUN) && (!known_s || !full_s);
   assign enq_s    = in_valid && in_ready && known_s;

   // Per-channel pointer/count update, storage snoop and tail write.
   always_comb begin
      deq_s    = '0;
      enq_ch_s = '0;
      for (int c = 0; c < 4; c++) begin
         deq_s[c]    = (cnt_q[c] != '0) && out_ready[c];
         enq_ch_s[c] = enq_s && (chan_s == 2'(c));
         for (int d = 0; d < DEPTH; d++) begin
            mem_d[c][d] = snoop(mem_q[c][d], cdb_valid, cdb_tag, cdb_data);
         end
         if (flush) begin
            head_d[c] = '0;
            tail_d[c] = '0;
            cnt_d[c]  = '0;
         end else begin
            head_d[c] = head_q[c] + PTR_W'(deq_s[c]);
            tail_d[c] = tail_q[c] + PTR_W'(enq_ch_s[c]);
            cnt_d[c]  = cnt_q[c] + CNT_W'(enq_ch_s[c]) - CNT_W'(deq_s[c]);
         end
         if (enq_ch_s[c]) begin
            mem_d[c][tail_q[c]] = new_s;
         end else begin
            mem_d[c][tail_q[c]] = mem_d[c][tail_q[c]];
         end
      end
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 4; c++) begin
            head_q[c] <= '0;
            tail_q[c] <= '0;
            cnt_q[c]  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[c][d] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            head_q[c] <= head_d[c];
            tail_q[c] <= tail_d[c];
            cnt_q[c]  <= cnt_d[c];
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[c][d] <= mem_d[c][d];
            end
         end
      end
   end

   // Branch-hold FSM and the dropped-instruction pulse; flush wins over everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         illegal_q <= 1'b0;
      end else if (flush) begin
         state_q   <= ST_RUN;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= in_valid && in_ready && !known_s;
         case (state_q)
            ST_RUN: begin
               if (enq_s && br_s) state_q <= ST_BR_HOLD;
               else               state_q <= ST_RUN;
            end
            ST_BR_HOLD: begin
               if (br_resolve) state_q <= ST_RUN;
               else            state_q <= ST_BR_HOLD;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // Head presentation; an empty channel shows an all-zero entry.
   always_comb begin
      out_valid = '0;
      out_count = '0;
      out_data  = '0;
      for (int c = 0; c < 4; c++) begin
         out_valid[c]                = (cnt_q[c] != '0);
         out_count[c*CNT_W +: CNT_W] = cnt_q[c];
         if (cnt_q[c] != '0) begin
            out_data[c*PW +: PW] = mem_q[c][head_q[c]];
         end else begin
            out_data[c*PW +: PW] = '0;
         end
      end
   end

   assign illegal = illegal_q;

endmodule
